life_array_param: RTL and testbench

Parametrised Conway life array: a ROWS x COLS grid of cells that each advance one generation per update. It supports row-wide read/write access, optional toroidal wrap, and a multi-generation run engine with busy/done handshake, generation counter and stable/extinct status. It is the generalised successor to the fixed 8x8 tile-selected array and sits between the host load/readout logic and any larger tiled fabric. When WRAP=0, the edge inputs connect it to neighbouring arrays.

---
 rtl/life_array_param.sv | 153 +++++++++++++++
 tb/tb_life_array_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_array_param.sv
// rtl/life_array_param.sv - parametrised Conway life array (B3/S23) with row access and multi-generation run engine
module life_array_param #(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int WRAP = 0,
   parameter int RW   = $clog2(ROWS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            write_enb,
   input  logic [RW-1:0]   wr_row,
   input  logic [COLS-1:0] wr_data,
   input  logic [RW-1:0]   rd_row,
   output logic [COLS-1:0] rd_data,
   input  logic [COLS-1:0] n,
   input  logic [COLS-1:0] s,
   input  logic [ROWS-1:0] w,
   input  logic [ROWS-1:0] e,
   input  logic            nw,
   input  logic            ne,
   input  logic            sw,
   input  logic            se,
   input  logic            step,
   input  logic            run_start,
   input  logic [15:0]     run_count,
   output logic            busy,
   output logic            done,
   output logic [15:0]     gen_count,
   output logic            stable,
   output logic            extinct
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, state_nxt;
   logic [COLS-1:0] grid_q [ROWS];
   logic [COLS-1:0] nxt    [ROWS];
   // Grid padded by one ring: bit 0 is column -1, bit COLS+1 is column COLS.
   logic [COLS+1:0] ext    [ROWS+2];
   logic [15:0]     remaining;
   logic            changed, alive;
   logic            do_write, do_gen, do_load, done_nxt;

   generate
      if (WRAP != 0) begin : g_wrap
         logic unused_edges;
         assign unused_edges = ^{n, s, w, e, nw, ne, sw, se};

         always_comb begin
            ext[0]      = {grid_q[ROWS-1][0], grid_q[ROWS-1], grid_q[ROWS-1][COLS-1]};
            ext[ROWS+1] = {grid_q[0][0], grid_q[0], grid_q[0][COLS-1]};
            for (int r = 0; r < ROWS; r++)
               ext[r+1] = {grid_q[r][0], grid_q[r], grid_q[r][COLS-1]};
         end
      end else begin : g_edge
         always_comb begin
            ext[0]      = {ne, n, nw};
            ext[ROWS+1] = {se, s, sw};
            for (int r = 0; r < ROWS; r++)
               ext[r+1] = {e[r], grid_q[r], w[r]};
         end
      end
   endgenerate

   always_comb begin
      logic [3:0] cnt;
      cnt = '0;
      for (int r = 0; r < ROWS; r++) begin
         nxt[r] = '0;
         for (int c = 0; c < COLS; c++) begin
            cnt = 4'(ext[r][c])   + 4'(ext[r][c+1])   + 4'(ext[r][c+2])
                + 4'(ext[r+1][c])                     + 4'(ext[r+1][c+2])
                + 4'(ext[r+2][c]) + 4'(ext[r+2][c+1]) + 4'(ext[r+2][c+2]);
            nxt[r][c] = (cnt == 4'd3) || (ext[r+1][c+1] && (cnt == 4'd2));
         end
      end
   end

   always_comb begin
      changed = 1'b0;
      alive   = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         changed = changed | (|(nxt[r] ^ grid_q[r]));
         alive   = alive | (|grid_q[r]);
      end
   end

   assign extinct = ~alive;
   assign rd_data = (int'(rd_row) < ROWS) ? grid_q[rd_row] : '0;
   assign busy    = (state == RUN);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Command arbitration: write beats run_start beats step; all ignored mid-run.
   always_comb begin
      state_nxt = state;
      do_write  = 1'b0;
      do_gen    = 1'b0;
      do_load   = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (write_enb) begin
               do_write = 1'b1;
            end else if (run_start) begin
               if (run_count == 16'd0) begin
                  done_nxt = 1'b1;
               end else begin
                  do_load   = 1'b1;
                  state_nxt = RUN;
               end
            end else if (step) begin
               do_gen = 1'b1;
            end
         end
         RUN: begin
            do_gen = 1'b1;
            if ((remaining == 16'd1) || !changed) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         remaining <= '0;
         done      <= 1'b0;
         gen_count <= '0;
         stable    <= 1'b0;
         for (int r = 0; r < ROWS; r++) grid_q[r] <= '0;
      end else begin
         done <= done_nxt;
         if (do_write) begin
            if (int'(wr_row) < ROWS) grid_q[wr_row] <= wr_data;
            gen_count <= '0;
            stable    <= 1'b0;
         end
         if (do_load) remaining <= run_count;
         if (do_gen) begin
            for (int r = 0; r < ROWS; r++) grid_q[r] <= nxt[r];
            gen_count <= gen_count + 16'd1;
            stable    <= ~changed;
            if (state == RUN) remaining <= remaining - 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_life_array_param.sv
// tb/tb_life_array_param.sv - directed self-checking bench for life_array_param
module tb_life_array_param;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        zero1 = 1'b0;
   // 8x8 group: dut_a WRAP=0, dut_b WRAP=1, shared stimulus
   logic        we8 = 0, step8 = 0, start8 = 0;
   logic [2:0]  wrow8 = 0, rrow8 = 0;
   logic [7:0]  wdata8 = 0, n8 = 0, s8 = 0, w8 = 0, e8 = 0;
   logic [15:0] count8 = 0;
   logic [7:0]  rd_a, rd_b;
   logic        busy_a, busy_b, done_a, done_b, stable_a, stable_b, ext_a, ext_b;
   logic [15:0] gen_a, gen_b;
   // 6x6 group: dut_c WRAP=1, dut_d WRAP=0
   logic        we6 = 0, step6 = 0, start6 = 0;
   logic [2:0]  wrow6 = 0, rrow6 = 0;
   logic [5:0]  wdata6 = 0, z6 = 0;
   logic [15:0] count6 = 0;
   logic [5:0]  rd_c, rd_d;
   logic        busy_c, busy_d, done_c, done_d, stable_c, stable_d, ext_c, ext_d;
   logic [15:0] gen_c, gen_d;

   int tests = 0;
   int errors = 0;

   life_array_param #(.ROWS(8), .COLS(8), .WRAP(0)) dut_a (
      .clk(clk), .reset(reset), .write_enb(we8), .wr_row(wrow8), .wr_data(wdata8),
      .rd_row(rrow8), .rd_data(rd_a), .n(n8), .s(s8), .w(w8), .e(e8),
      .nw(zero1), .ne(zero1), .sw(zero1), .se(zero1), .step(step8),
      .run_start(start8), .run_count(count8), .busy(busy_a), .done(done_a),
      .gen_count(gen_a), .stable(stable_a), .extinct(ext_a));

   life_array_param #(.ROWS(8), .COLS(8), .WRAP(1)) dut_b (
      .clk(clk), .reset(reset), .write_enb(we8), .wr_row(wrow8), .wr_data(wdata8),
      .rd_row(rrow8), .rd_data(rd_b), .n(n8), .s(s8), .w(w8), .e(e8),
      .nw(zero1), .ne(zero1), .sw(zero1), .se(zero1), .step(step8),
      .run_start(start8), .run_count(count8), .busy(busy_b), .done(done_b),
      .gen_count(gen_b), .stable(stable_b), .extinct(ext_b));

   life_array_param #(.ROWS(6), .COLS(6), .WRAP(1)) dut_c (
      .clk(clk), .reset(reset), .write_enb(we6), .wr_row(wrow6), .wr_data(wdata6),
      .rd_row(rrow6), .rd_data(rd_c), .n(z6), .s(z6), .w(z6), .e(z6),
      .nw(zero1), .ne(zero1), .sw(zero1), .se(zero1), .step(step6),
      .run_start(start6), .run_count(count6), .busy(busy_c), .done(done_c),
      .gen_count(gen_c), .stable(stable_c), .extinct(ext_c));

   life_array_param #(.ROWS(6), .COLS(6), .WRAP(0)) dut_d (
      .clk(clk), .reset(reset), .write_enb(we6), .wr_row(wrow6), .wr_data(wdata6),
      .rd_row(rrow6), .rd_data(rd_d), .n(z6), .s(z6), .w(z6), .e(z6),
      .nw(zero1), .ne(zero1), .sw(zero1), .se(zero1), .step(step6),
      .run_start(start6), .run_count(count6), .busy(busy_d), .done(done_d),
      .gen_count(gen_d), .stable(stable_d), .extinct(ext_d));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // All tasks start and end just after a falling edge.
   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wr8(input logic [2:0] r, input logic [7:0] d);
      we8 = 1'b1; wrow8 = r; wdata8 = d;
      @(negedge clk);
      we8 = 1'b0;
   endtask

   task automatic wr6(input logic [2:0] r, input logic [5:0] d);
      we6 = 1'b1; wrow6 = r; wdata6 = d;
      @(negedge clk);
      we6 = 1'b0;
   endtask

   task automatic rd8(input logic [2:0] r, output logic [7:0] a, output logic [7:0] b);
      rrow8 = r;
      #1;
      a = rd_a;
      b = rd_b;
   endtask

   task automatic step_a();
      step8 = 1'b1;
      @(negedge clk);
      step8 = 1'b0;
   endtask

   task automatic run8(input logic [15:0] cnt, output int busy_cycles, output int done_pulses);
      busy_cycles = 0;
      done_pulses = 0;
      start8 = 1'b1; count8 = cnt;
      @(negedge clk);
      start8 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         busy_cycles += int'(busy_a);
         done_pulses += int'(done_a);
         @(negedge clk);
      end
   endtask

   logic [7:0] ra, rb;
   logic [5:0] glider_c [6] = '{6'h02, 6'h04, 6'h07, 6'h00, 6'h00, 6'h00};
   logic [5:0] block_d  [6] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h30, 6'h30};
   int bc, dc, bc2, dc2;

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // reset state
      rd8(3'd0, ra, rb);
      check("reset rd_data", ra, 8'h00);
      check("reset busy", busy_a, 1'b0);
      check("reset done", done_a, 1'b0);
      check("reset gen_count", gen_a, 16'd0);
      check("reset stable", stable_a, 1'b0);
      check("reset extinct", ext_a, 1'b1);

      // lone cell dies after one step
      wr8(3'd0, 8'h01);
      rd8(3'd0, ra, rb);
      check("write visible", ra, 8'h01);
      check("extinct after write", ext_a, 1'b0);
      step_a();
      rd8(3'd0, ra, rb);
      check("lone row0", ra, 8'h00);
      check("lone gen", gen_a, 16'd1);
      check("lone extinct", ext_a, 1'b1);
      check("lone stable", stable_a, 1'b0);

      // blinker, 4 generations
      do_reset();
      wr8(3'd3, 8'h1C);
      run8(16'd4, bc, dc);
      check("blinker busy cycles", bc, 4);
      check("blinker done pulses", dc, 1);
      rd8(3'd3, ra, rb);
      check("blinker row3", ra, 8'h1C);
      rd8(3'd2, ra, rb);
      check("blinker row2", ra, 8'h00);
      rd8(3'd4, ra, rb);
      check("blinker row4", ra, 8'h00);
      check("blinker gen", gen_a, 16'd4);
      check("blinker stable", stable_a, 1'b0);

      // block stops early
      do_reset();
      wr8(3'd3, 8'h18);
      wr8(3'd4, 8'h18);
      run8(16'd100, bc, dc);
      check("block busy cycles", bc, 1);
      check("block done pulses", dc, 1);
      check("block gen", gen_a, 16'd1);
      check("block stable", stable_a, 1'b1);
      rd8(3'd3, ra, rb);
      check("block row3", ra, 8'h18);
      rd8(3'd4, ra, rb);
      check("block row4", ra, 8'h18);

      // run_count zero: done pulse only
      start8 = 1'b1; count8 = 16'd0;
      @(negedge clk);
      start8 = 1'b0;
      check("zero run done", done_a, 1'b1);
      check("zero run busy", busy_a, 1'b0);
      @(negedge clk);
      check("zero run done clears", done_a, 1'b0);
      check("zero run gen", gen_a, 16'd1);

      // north edge input births
      do_reset();
      n8 = 8'h0E;
      step_a();
      n8 = 8'h00;
      rd8(3'd0, ra, rb);
      check("edge n WRAP0 row0", ra, 8'h04);
      check("edge n WRAP1 row0", rb, 8'h00);

      // 6x6 glider: torus returns after 24, bounded decays to block
      do_reset();
      for (int r = 0; r < 3; r++) wr6(3'(r), glider_c[r]);
      start6 = 1'b1; count6 = 16'd24;
      @(negedge clk);
      start6 = 1'b0;
      bc = 0; dc = 0; bc2 = 0; dc2 = 0;
      for (int i = 0; i < 40; i++) begin
         bc  += int'(busy_c);
         dc  += int'(done_c);
         bc2 += int'(busy_d);
         dc2 += int'(done_d);
         @(negedge clk);
      end
      check("glider torus busy", bc, 24);
      check("glider torus done", dc, 1);
      check("glider torus gen", gen_c, 16'd24);
      check("glider torus stable", stable_c, 1'b0);
      check("glider bounded busy", bc2, 16);
      check("glider bounded done", dc2, 1);
      check("glider bounded gen", gen_d, 16'd16);
      check("glider bounded stable", stable_d, 1'b1);
      for (int r = 0; r < 6; r++) begin
         rrow6 = 3'(r);
         #1;
         check($sformatf("glider torus row%0d", r), rd_c, glider_c[r]);
         check($sformatf("glider bounded row%0d", r), rd_d, block_d[r]);
      end

      // reset mid-run aborts silently
      do_reset();
      wr8(3'd3, 8'h1C);
      start8 = 1'b1; count8 = 16'd10;
      @(negedge clk);
      start8 = 1'b0;
      check("abort busy before", busy_a, 1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort busy", busy_a, 1'b0);
      check("abort gen", gen_a, 16'd0);
      rd8(3'd3, ra, rb);
      check("abort row3", ra, 8'h00);
      check("abort extinct", ext_a, 1'b1);
      dc = 0;
      for (int i = 0; i < 15; i++) begin
         dc += int'(done_a);
         @(negedge clk);
      end
      check("abort no done", dc, 0);

      // write wins over same-cycle step and run_start
      we8 = 1'b1; wrow8 = 3'd0; wdata8 = 8'h01; step8 = 1'b1;
      @(negedge clk);
      we8 = 1'b0; step8 = 1'b0;
      rd8(3'd0, ra, rb);
      check("write+step row0", ra, 8'h01);
      check("write+step gen", gen_a, 16'd0);
      @(negedge clk);
      rd8(3'd0, ra, rb);
      check("write+step row0 later", ra, 8'h01);
      we8 = 1'b1; wrow8 = 3'd1; wdata8 = 8'h80; start8 = 1'b1; count8 = 16'd5;
      @(negedge clk);
      we8 = 1'b0; start8 = 1'b0;
      check("write+run busy", busy_a, 1'b0);
      rd8(3'd1, ra, rb);
      check("write+run row1", ra, 8'h80);
      @(negedge clk);
      check("write+run no done", done_a, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
